// File: rtl/snoop_cache_ctrl.sv
// snoop_cache_ctrl: direct-mapped write-back cache controller, MSI snooping.
// Two lines, one CPU request at a time, drives a 4x2-bit registered memory.
module snoop_cache_ctrl #(
    parameter logic CACHE_ID = 1'b0
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [1:0] cpu_addr,
    input  logic [1:0] cpu_wdata,
    output logic       cpu_ready,
    output logic [1:0] cpu_rdata,
    output logic       bus_valid,
    output logic [1:0] bus_op,
    output logic [1:0] bus_addr,
    output logic       bus_src,
    input  logic       snoop_valid,
    input  logic [1:0] snoop_op,
    input  logic [1:0] snoop_addr,
    input  logic       snoop_src,
    output logic       snoop_flush,
    output logic [1:0] flush_data,
    output logic [1:0] mem_tag,
    output logic [1:0] mem_data,
    output logic       mem_writeEn,
    input  logic [1:0] mem_q
);

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_M = 2'b10;

    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_RDX  = 2'b10;
    localparam logic [1:0] OP_UPGR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        FETCH,
        WAIT_MEM,
        RESPOND
    } state_t;

    state_t          state;
    state_t          state_n;

    logic [1:0][1:0] ln_st;
    logic [1:0]      ln_tag;
    logic [1:0][1:0] ln_dat;
    logic [1:0][1:0] snp_st;

    logic            req_we;
    logic [1:0]      req_addr;
    logic [1:0]      req_wdata;

    logic            idx;
    logic            sidx;
    logic            hit;

    logic            ln_wr;
    logic [1:0]      wr_st;
    logic            wr_tag;
    logic [1:0]      wr_dat;

    assign idx     = req_addr[0];
    assign sidx    = snoop_addr[0];
    assign bus_src = CACHE_ID;

    // Snoop reaction: post-snoop line states and the flush of a dirty line
    always_comb begin
        snp_st      = ln_st;
        snoop_flush = 1'b0;
        flush_data  = 2'b00;
        if (snoop_valid && (snoop_src != CACHE_ID) &&
            (ln_st[sidx] != ST_I) && (ln_tag[sidx] == snoop_addr[1])) begin
            unique case (1'b1)
                (snoop_op == OP_RD): begin
                    if (ln_st[sidx] == ST_M) begin
                        snoop_flush  = 1'b1;
                        flush_data   = ln_dat[sidx];
                        snp_st[sidx] = ST_S;
                    end
                end
                (snoop_op == OP_RDX),
                (snoop_op == OP_UPGR): begin
                    if (ln_st[sidx] == ST_M) begin
                        snoop_flush = 1'b1;
                        flush_data  = ln_dat[sidx];
                    end
                    snp_st[sidx] = ST_I;
                end
                default: ;
            endcase
        end
    end

    // Hit test against the post-snoop state of the indexed line
    always_comb begin
        hit = (snp_st[idx] != ST_I) && (ln_tag[idx] == req_addr[1]);
    end

    // Next state, Moore outputs and the FSM's own line update
    always_comb begin
        state_n     = state;
        cpu_ready   = 1'b0;
        cpu_rdata   = 2'b00;
        bus_valid   = 1'b0;
        bus_op      = 2'b00;
        bus_addr    = 2'b00;
        mem_tag     = 2'b00;
        mem_data    = 2'b00;
        mem_writeEn = 1'b0;
        ln_wr       = 1'b0;
        wr_st       = ST_I;
        wr_tag      = ln_tag[idx];
        wr_dat      = ln_dat[idx];
        unique case (state)
            IDLE: begin
                if (cpu_req) state_n = COMPARE;
            end
            COMPARE: begin
                if (hit) begin
                    state_n = RESPOND;
                    if (req_we) begin
                        ln_wr  = 1'b1;
                        wr_st  = ST_M;
                        wr_tag = req_addr[1];
                        wr_dat = req_wdata;
                        if (snp_st[idx] == ST_S) begin
                            bus_valid = 1'b1;
                            bus_op    = OP_UPGR;
                            bus_addr  = req_addr;
                        end
                    end
                end else if (snp_st[idx] == ST_M) begin
                    state_n = WRITEBACK;
                end else begin
                    state_n = FETCH;
                end
            end
            WRITEBACK: begin
                mem_writeEn = 1'b1;
                mem_tag     = {ln_tag[idx], idx};
                mem_data    = ln_dat[idx];
                ln_wr       = 1'b1;
                wr_st       = ST_I;
                state_n     = FETCH;
            end
            FETCH: begin
                mem_tag   = req_addr;
                bus_valid = 1'b1;
                bus_op    = req_we ? OP_RDX : OP_RD;
                bus_addr  = req_addr;
                state_n   = WAIT_MEM;
            end
            WAIT_MEM: begin
                ln_wr   = 1'b1;
                wr_st   = req_we ? ST_M : ST_S;
                wr_tag  = req_addr[1];
                wr_dat  = req_we ? req_wdata : mem_q;
                state_n = RESPOND;
            end
            RESPOND: begin
                cpu_ready = 1'b1;
                cpu_rdata = ln_dat[idx];
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge Clock) begin
        if (!Resetn) state <= IDLE;
        else         state <= state_n;
    end

    // Request latch, captured only when a request is accepted in IDLE
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            req_we    <= 1'b0;
            req_addr  <= 2'b00;
            req_wdata <= 2'b00;
        end else if (state == IDLE && cpu_req) begin
            req_we    <= cpu_we;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
        end
    end

    // Line storage: snoop updates first, FSM writes take priority
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            ln_st  <= '0;
            ln_tag <= '0;
            ln_dat <= '0;
        end else begin
            ln_st <= snp_st;
            if (ln_wr) begin
                ln_st[idx]  <= wr_st;
                ln_tag[idx] <= wr_tag;
                ln_dat[idx] <= wr_dat;
            end
        end
    end

endmodule

// File: doc/snoop_cache_ctrl.md
Name: snoop_cache_ctrl

Overview:
- Per-processor, direct-mapped, write-back cache controller running the MSI snooping protocol.
- Sits directly upstream of the shared 4x2-bit memory block; drives its tag/data/writeEn port and consumes its registered Q output.
- Serves one CPU request at a time, broadcasts coherence ops on the shared bus, and reacts to snooped ops from other caches.

Parameters:
CACHE_ID, 0, 1-bit identity placed on bus_src; snoops with snoop_src==CACHE_ID are ignored.

Ports:
Clock  in  1  system clock, all state updates on rising edge
Resetn  in  1  synchronous active-low reset
cpu_req  in  1  request valid, sampled in IDLE only
cpu_we  in  1  1=write, 0=read
cpu_addr  in  2  word address; index=addr[0], tag=addr[1]
cpu_wdata  in  2  write data
cpu_ready  out  1  one-cycle completion pulse
cpu_rdata  out  2  read data, valid while cpu_ready=1
bus_valid  out  1  one-cycle broadcast strobe
bus_op  out  2  01 BusRd, 10 BusRdX, 11 BusUpgr
bus_addr  out  2  broadcast address
bus_src  out  1  equals CACHE_ID
snoop_valid  in  1  snooped op strobe
snoop_op  in  2  encoding as bus_op
snoop_addr  in  2  snooped address
snoop_src  in  1  originator id
snoop_flush  out  1  one-cycle pulse: this cache supplied a dirty line
flush_data  out  2  dirty data, valid with snoop_flush
mem_tag  out  2  memory address
mem_data  out  2  memory write data
mem_writeEn  out  1  1=write at next edge, 0=read (Q updates at that edge)
mem_q  in  2  memory read data

Behaviour:
- Storage: 2 lines, each with state {I=00, S=01, M=10}, 1-bit tag, and 2-bit data.
- Reset (Resetn=0 at an edge):
  - All lines go to I with tag=0 and data=0; FSM goes to IDLE.
  - All outputs are 0, including mem_tag, mem_data and mem_writeEn.
  - Reset mid-operation abandons the request: no cpu_ready, and no memory write is issued after the reset edge.
- FSM states: IDLE, COMPARE, WRITEBACK, FETCH, WAIT_MEM, RESPOND.
- IDLE: on cpu_req=1, latch cpu_we, cpu_addr and cpu_wdata, then go to COMPARE.
- COMPARE: hit = line state!=I && tag match, evaluated against post-snoop state (a same-cycle invalidating snoop on this line forces a miss).
  - Read hit (S or M): go to RESPOND.
  - Write hit in M: write data, go to RESPOND.
  - Write hit in S: bus_valid=1, bus_op=BusUpgr; line becomes M, write data, go to RESPOND.
  - Miss with victim in M: go to WRITEBACK.
  - Other miss: go to FETCH.
- WRITEBACK: mem_writeEn=1, mem_tag={victim tag,index}, mem_data=victim data; victim goes to I; next state FETCH.
- FETCH:
  - Memory side: mem_writeEn=0, mem_tag=latched addr.
  - Bus side: bus_valid=1, bus_op=BusRd (read) or BusRdX (write).
  - Next state WAIT_MEM.
- WAIT_MEM: fill the line from mem_q, tag=addr[1].
  - Read fill: state S.
  - Write fill: state M, data=latched wdata.
  - Next state RESPOND.
- RESPOND: cpu_ready=1, cpu_rdata=line data; next state IDLE.
- Latency from the req-sampling edge to cpu_ready: hit is 2 cycles; clean miss is 4 cycles; dirty miss is 5 cycles.
- Snoop handling, every cycle in every state, when snoop_valid=1, snoop_src!=CACHE_ID, and the indexed line is valid with matching tag:
  - BusRd on M: snoop_flush=1, flush_data=line data, line goes to S.
  - BusRd on S: no change.
  - BusRdX/BusUpgr on M: flush as above, then line goes to I.
  - BusRdX/BusUpgr on S: line goes to I.
- Snoop vs. fill on the same line: the WAIT_MEM fill overwrites any snoop update in that cycle.
- Outputs driven only in their state; mem_writeEn is 0 in every state other than WRITEBACK.
- bus_valid is never asserted in two consecutive cycles.

Test Plan:
- Reset; memory initialised mem[a]=a.
  - Read addr 2 -> one BusRd addr 2 in FETCH; cpu_rdata=10 and cpu_ready 4 cycles after req; line0 = S, tag 1.
  - Read addr 2 again -> cpu_ready after 2 cycles, rdata=10, no bus_valid, mem_writeEn stays 0.
- Write addr 2 data 01 while line0 is S -> one BusUpgr addr 2; line0 = M, data 01; cpu_ready after 2 cycles; no memory write.
- Then read addr 0 -> WRITEBACK with mem_tag=10, mem_data=01, mem_writeEn=1; then BusRd addr 0; rdata=00 after 5 cycles; a later read of addr 2 returns 01.
- Write addr 1 data 11 (miss) -> BusRdX, line1 = M; then snoop BusRd addr 1, src=1 -> snoop_flush=1, flush_data=11, line1 = S; then snoop BusRdX addr 1 -> line1 = I, no flush.
- Snoop with src=CACHE_ID on an M line -> no state change, no flush.
- Same-cycle snoop BusUpgr on an S line during a COMPARE write -> treated as a miss (FETCH issues BusRdX).
- Resetn=0 during FETCH -> next cycle all outputs 0, lines I, no cpu_ready.
